// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address controller for the PC register.
// Takes one flow command at a time, computes the next address and pulses
// pc_enable for one cycle so the PC loads it. CALL/RET use a small LIFO
// return-address stack. HALT and FAULT are terminal until Rst.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a command (cmd_ready=1)
// S_LOAD  | pc_enable=1 for one cycle, PC loads pc_newaddr
// S_HALT  | HALT executed; halted=1, commands ignored
// S_FAULT | stack over/underflow or illegal op; fault=1, commands ignored
module pc_sequencer #(
  parameter int AW          = 12,
  parameter int STACK_DEPTH = 4,
  localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           Rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic           cmd_cond,
  input  logic [AW-1:0]  cmd_target,
  input  logic [AW-1:0]  pc_in,
  output logic           pc_enable,
  output logic [AW-1:0]  pc_newaddr,
  output logic [SPW-1:0] sp,
  output logic           halted,
  output logic           fault
);

  // Stack storage is sized to a power of two so sp slices index it cleanly;
  // only the first STACK_DEPTH entries are ever written.
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HALT,
    S_FAULT
  } state_t;

  state_t         state;
  logic [AW-1:0]  stack [2**IW];
  logic [AW-1:0]  inc;
  logic [SPW-1:0] sp_m1;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;
  logic           stack_full;
  logic           stack_empty;

  assign cmd_ready   = (state == S_IDLE);
  assign inc         = pc_in + AW'(1);
  assign sp_m1       = sp - SPW'(1);
  assign push_idx    = sp[IW-1:0];
  assign pop_idx     = sp_m1[IW-1:0];
  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  // Sequencer FSM: command decode, address select, stack push/pop, strobe.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      pc_enable  <= 1'b0;
      pc_newaddr <= '0;
      sp         <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pc_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_NEXT: begin
                pc_newaddr <= inc;
                pc_enable  <= 1'b1;
                state      <= S_LOAD;
              end
              OP_JUMP: begin
                pc_newaddr <= cmd_target;
                pc_enable  <= 1'b1;
                state      <= S_LOAD;
              end
              OP_BRANCH: begin
                pc_newaddr <= cmd_cond ? cmd_target : inc;
                pc_enable  <= 1'b1;
                state      <= S_LOAD;
              end
              OP_CALL: begin
                if (stack_full) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
                end else begin
                  stack[push_idx] <= inc;
                  sp              <= sp + SPW'(1);
                  pc_newaddr      <= cmd_target;
                  pc_enable       <= 1'b1;
                  state           <= S_LOAD;
                end
              end
              OP_RET: begin
                if (stack_empty) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
                end else begin
                  sp         <= sp_m1;
                  pc_newaddr <= stack[pop_idx];
                  pc_enable  <= 1'b1;
                  state      <= S_LOAD;
                end
              end
              OP_HALT: begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
              default: begin
                state <= S_FAULT;
                fault <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD:  state <= S_IDLE;
        default: state <= state;
      endcase
    end
  end

endmodule
